// File: rtl/caf_pkg.sv
// caf_pkg: definitions shared by the cross-ambiguity sweep logic.
//   caf_state_e  - sweep sequencer state encoding (5 states, 3 bits)
//   IndexBits    - default arg_max index width
//   OutMaxBits   - default arg_max magnitude width
//   PhaseBits    - default frequency-shifter phase increment width
package caf_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StConfig = 3'd1,
    StWait   = 3'd2,
    StUpdate = 3'd3,
    StDone   = 3'd4
  } caf_state_e;

  localparam int unsigned IndexBits  = 4;
  localparam int unsigned OutMaxBits = 4;
  localparam int unsigned PhaseBits  = 10;

endpackage

// File: rtl/peak_tracker.sv
// peak_tracker: holds the global (max, index, bin) peak of a sweep.
// Ports:
//   clk, rst              - clock, synchronous active-high reset (clears the peak)
//   en                    - one-cycle update strobe for the current bin's result
//   first                 - current bin is bin 0; load unconditionally
//   in_max/in_index/in_bin - candidate result
//   out_max/out_index/out_bin - stored peak, held between updates
module peak_tracker
  import caf_pkg::*;
#(
  parameter int unsigned index_bits   = IndexBits,
  parameter int unsigned out_max_bits = OutMaxBits,
  parameter int unsigned bin_bits     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    first,
  input  logic [out_max_bits-1:0] in_max,
  input  logic [index_bits-1:0]   in_index,
  input  logic [bin_bits-1:0]     in_bin,
  output logic [out_max_bits-1:0] out_max,
  output logic [index_bits-1:0]   out_index,
  output logic [bin_bits-1:0]     out_bin
);

  // Strict compare: a tie keeps the earlier (lower) bin.
  logic load;
  assign load = en && (first || (in_max > out_max));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_max   <= '0;
      out_index <= '0;
      out_bin   <= '0;
    end else if (load) begin
      out_max   <= in_max;
      out_index <= in_index;
      out_bin   <= in_bin;
    end
  end

endmodule

// File: rtl/caf_sweep_ctrl.sv
// caf_sweep_ctrl: sequences the frequency-bin sweep of the cross-ambiguity search.
// Per bin it presents a phase increment, pulses bin_start, waits for one arg_max
// result, and folds it into the global peak; the peak is offered once per sweep.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - begin a sweep (only honoured in idle)
//   busy            - sweep in progress
//   phase_inc       - current bin's phase increment for the shifter
//   bin_start       - one-cycle pulse at the start of each bin
//   m_axis_tvalid, in_max, in_index, s_axis_tready - arg_max result handshake
//   s_axis_tvalid, out_max, out_index, out_bin, m_axis_tready - sweep result handshake
module caf_sweep_ctrl
  import caf_pkg::*;
#(
  parameter int unsigned num_bins     = 8,
  parameter int unsigned bin_bits     = 3,
  parameter int unsigned index_bits   = IndexBits,
  parameter int unsigned out_max_bits = OutMaxBits,
  parameter int unsigned phase_bits   = PhaseBits,
  parameter int unsigned phase_start  = 0,
  parameter int unsigned phase_step   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic [phase_bits-1:0]   phase_inc,
  output logic                    bin_start,
  input  logic                    m_axis_tvalid,
  input  logic [out_max_bits-1:0] in_max,
  input  logic [index_bits-1:0]   in_index,
  output logic                    s_axis_tready,
  output logic [out_max_bits-1:0] out_max,
  output logic [index_bits-1:0]   out_index,
  output logic [bin_bits-1:0]     out_bin,
  output logic                    s_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam logic [bin_bits-1:0]   LastBin    = bin_bits'(num_bins - 1);
  localparam logic [phase_bits-1:0] PhaseStart = phase_bits'(phase_start);
  localparam logic [phase_bits-1:0] PhaseStep  = phase_bits'(phase_step);

  caf_state_e              state_q;
  logic [bin_bits-1:0]     bin_q;
  logic [out_max_bits-1:0] res_max_q;
  logic [index_bits-1:0]   res_index_q;

  // Outputs are registered: each transition also sets the outputs of the target state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      busy          <= 1'b0;
      bin_start     <= 1'b0;
      s_axis_tready <= 1'b0;
      s_axis_tvalid <= 1'b0;
      phase_inc     <= PhaseStart;
      bin_q         <= '0;
      res_max_q     <= '0;
      res_index_q   <= '0;
    end else begin
      bin_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StConfig;
            busy      <= 1'b1;
            bin_start <= 1'b1;
            bin_q     <= '0;
            phase_inc <= PhaseStart;
          end
        end
        StConfig: begin
          state_q       <= StWait;
          s_axis_tready <= 1'b1;
        end
        StWait: begin
          if (m_axis_tvalid && s_axis_tready) begin
            state_q       <= StUpdate;
            s_axis_tready <= 1'b0;
            res_max_q     <= in_max;
            res_index_q   <= in_index;
          end
        end
        StUpdate: begin
          if (bin_q == LastBin) begin
            state_q       <= StDone;
            s_axis_tvalid <= 1'b1;
          end else begin
            state_q   <= StConfig;
            bin_start <= 1'b1;
            bin_q     <= bin_q + 1'b1;
            phase_inc <= phase_inc + PhaseStep;
          end
        end
        StDone: begin
          if (m_axis_tready) begin
            state_q       <= StIdle;
            busy          <= 1'b0;
            s_axis_tvalid <= 1'b0;
          end
        end
        default: begin
          state_q       <= StIdle;
          busy          <= 1'b0;
          s_axis_tready <= 1'b0;
          s_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

  peak_tracker #(
    .index_bits  (index_bits),
    .out_max_bits(out_max_bits),
    .bin_bits    (bin_bits)
  ) u_peak (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == StUpdate),
    .first    (bin_q == '0),
    .in_max   (res_max_q),
    .in_index (res_index_q),
    .in_bin   (bin_q),
    .out_max  (out_max),
    .out_index(out_index),
    .out_bin  (out_bin)
  );

endmodule

// File: tb/tb_caf_sweep_ctrl.sv
// Directed bench for caf_sweep_ctrl. Three instances share clk/rst:
//   0: num_bins=1; 1: num_bins=4; 2: num_bins=3, phase_start=1022, phase_step=3.
module tb_caf_sweep_ctrl;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s[NI], busy_s[NI], bin_start_s[NI], valid_s[NI];
  logic       tready_s[NI], tvalid_s[NI], mready_s[NI];
  logic [9:0] phase_s[NI];
  logic [3:0] in_max_s[NI], in_idx_s[NI], out_max_s[NI], out_idx_s[NI];
  logic [2:0] out_bin_s[NI];

  int checks = 0;
  int failures = 0;

  // Feed-task inputs and observations.
  logic [3:0] fd_max[8], fd_idx[8];
  logic [9:0] log_phase[8];
  int         log_nbs, log_hs, log_cycles;
  bit         log_timeout;

  always #5 clk = ~clk;

  caf_sweep_ctrl #(.num_bins(1)) u_one (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .phase_inc(phase_s[0]),
    .bin_start(bin_start_s[0]), .m_axis_tvalid(valid_s[0]), .in_max(in_max_s[0]),
    .in_index(in_idx_s[0]), .s_axis_tready(tready_s[0]), .out_max(out_max_s[0]),
    .out_index(out_idx_s[0]), .out_bin(out_bin_s[0]), .s_axis_tvalid(tvalid_s[0]),
    .m_axis_tready(mready_s[0])
  );

  caf_sweep_ctrl #(.num_bins(4)) u_four (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .phase_inc(phase_s[1]),
    .bin_start(bin_start_s[1]), .m_axis_tvalid(valid_s[1]), .in_max(in_max_s[1]),
    .in_index(in_idx_s[1]), .s_axis_tready(tready_s[1]), .out_max(out_max_s[1]),
    .out_index(out_idx_s[1]), .out_bin(out_bin_s[1]), .s_axis_tvalid(tvalid_s[1]),
    .m_axis_tready(mready_s[1])
  );

  caf_sweep_ctrl #(.num_bins(3), .phase_start(1022), .phase_step(3)) u_wrap (
    .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy_s[2]), .phase_inc(phase_s[2]),
    .bin_start(bin_start_s[2]), .m_axis_tvalid(valid_s[2]), .in_max(in_max_s[2]),
    .in_index(in_idx_s[2]), .s_axis_tready(tready_s[2]), .out_max(out_max_s[2]),
    .out_index(out_idx_s[2]), .out_bin(out_bin_s[2]), .s_axis_tvalid(tvalid_s[2]),
    .m_axis_tready(mready_s[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Optionally pulses start, then answers every ready with the next table entry.
  // Returns when the sweep result is valid, or in WAIT once n_stop results were given.
  task automatic feed(input int k, input int n_stop, input bit do_start);
    log_nbs = 0; log_hs = 0; log_cycles = 0; log_timeout = 1'b0;
    if (do_start) start_s[k] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      log_cycles++;
      start_s[k] = 1'b0;
      if (valid_s[k]) begin
        valid_s[k] = 1'b0;
        log_hs++;
      end
      if (bin_start_s[k]) begin
        if (log_nbs < 8) log_phase[log_nbs] = phase_s[k];
        log_nbs++;
      end
      if (tvalid_s[k]) return;
      if (tready_s[k]) begin
        if (log_hs >= n_stop) return;
        valid_s[k]  = 1'b1;
        in_max_s[k] = fd_max[log_hs];
        in_idx_s[k] = fd_idx[log_hs];
      end
    end
    log_timeout = 1'b1;
  endtask

  task automatic release_result(input int k);
    mready_s[k] = 1'b1;
    tick();
    mready_s[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 0; valid_s[k] = 0; mready_s[k] = 0; in_max_s[k] = 0; in_idx_s[k] = 0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      logic [9:0] ph;
      ph = (k == 2) ? 10'd1022 : 10'd0;
      checks++;
      if (busy_s[k] !== 1'b0 || bin_start_s[k] !== 1'b0) begin
        failures++; $display("FAIL reset_busy_bstart[%0d]: got %b%b want 00", k, busy_s[k],
                             bin_start_s[k]);
      end
      checks++;
      if (tready_s[k] !== 1'b0 || tvalid_s[k] !== 1'b0) begin
        failures++; $display("FAIL reset_ready_valid[%0d]: got %b%b want 00", k,
                             tready_s[k], tvalid_s[k]);
      end
      checks++;
      if (phase_s[k] !== ph) begin
        failures++; $display("FAIL reset_phase[%0d]: got %0d want %0d", k, phase_s[k], ph);
      end
      checks++;
      if (out_max_s[k] !== 4'd0 || out_idx_s[k] !== 4'd0 || out_bin_s[k] !== 3'd0) begin
        failures++; $display("FAIL reset_out[%0d]: got %0d/%0d/%0d want 0/0/0", k,
                             out_max_s[k], out_idx_s[k], out_bin_s[k]);
      end
    end
  endtask

  task automatic test_single_bin();
    fd_max[0] = 4'd9; fd_idx[0] = 4'd3;
    feed(0, 1, 1'b1);
    checks++;
    if (log_timeout !== 1'b0) begin failures++; $display("FAIL single_timeout: got 1 want 0"); end
    checks++;
    if (log_nbs != 1) begin failures++; $display("FAIL single_nbs: got %0d want 1", log_nbs); end
    checks++;
    if (log_cycles != 4) begin
      failures++; $display("FAIL single_latency: got %0d want 4", log_cycles);
    end
    checks++;
    if (out_max_s[0] !== 4'd9 || out_idx_s[0] !== 4'd3 || out_bin_s[0] !== 3'd0) begin
      failures++; $display("FAIL single_out: got %0d/%0d/%0d want 9/3/0", out_max_s[0],
                           out_idx_s[0], out_bin_s[0]);
    end
    checks++;
    if (busy_s[0] !== 1'b1) begin failures++; $display("FAIL single_busy: got 0 want 1"); end
    release_result(0);
    checks++;
    if (tvalid_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      failures++; $display("FAIL single_release: got v%b b%b want v0 b0", tvalid_s[0],
                           busy_s[0]);
    end
  endtask

  task automatic test_four_bins();
    fd_max[0] = 2; fd_max[1] = 7; fd_max[2] = 5; fd_max[3] = 7;
    fd_idx[0] = 1; fd_idx[1] = 6; fd_idx[2] = 2; fd_idx[3] = 9;
    feed(1, 4, 1'b1);
    checks++;
    if (log_timeout !== 1'b0 || log_cycles != 13) begin
      failures++; $display("FAIL four_latency: got %0d (to=%b) want 13", log_cycles, log_timeout);
    end
    checks++;
    if (log_nbs != 4) begin failures++; $display("FAIL four_nbs: got %0d want 4", log_nbs); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (log_phase[b] !== 10'(b)) begin
        failures++; $display("FAIL four_phase[%0d]: got %0d want %0d", b, log_phase[b], b);
      end
    end
    checks++;
    if (out_max_s[1] !== 4'd7 || out_idx_s[1] !== 4'd6 || out_bin_s[1] !== 3'd1) begin
      failures++; $display("FAIL four_out: got %0d/%0d/%0d want 7/6/1", out_max_s[1],
                           out_idx_s[1], out_bin_s[1]);
    end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (tvalid_s[1] !== 1'b1 || out_max_s[1] !== 4'd7 || out_idx_s[1] !== 4'd6 ||
          out_bin_s[1] !== 3'd1) begin
        failures++; $display("FAIL hold[%0d]: got v%b %0d/%0d/%0d want v1 7/6/1", i,
                             tvalid_s[1], out_max_s[1], out_idx_s[1], out_bin_s[1]);
      end
    end
    release_result(1);
    checks++;
    if (tvalid_s[1] !== 1'b0 || busy_s[1] !== 1'b0) begin
      failures++; $display("FAIL hold_release: got v%b b%b want v0 b0", tvalid_s[1], busy_s[1]);
    end
    checks++;
    if (out_max_s[1] !== 4'd7 || out_idx_s[1] !== 4'd6 || out_bin_s[1] !== 3'd1) begin
      failures++; $display("FAIL hold_retain: got %0d/%0d/%0d want 7/6/1", out_max_s[1],
                           out_idx_s[1], out_bin_s[1]);
    end
  endtask

  task automatic test_phase_wrap();
    logic [9:0] exp_ph[3];
    exp_ph[0] = 10'd1022; exp_ph[1] = 10'd1; exp_ph[2] = 10'd4;
    fd_max[0] = 3; fd_max[1] = 3; fd_max[2] = 4;
    fd_idx[0] = 0; fd_idx[1] = 5; fd_idx[2] = 5;
    feed(2, 3, 1'b1);
    checks++;
    if (log_timeout !== 1'b0 || log_nbs != 3) begin
      failures++; $display("FAIL wrap_nbs: got %0d (to=%b) want 3", log_nbs, log_timeout);
    end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (log_phase[b] !== exp_ph[b]) begin
        failures++; $display("FAIL wrap_phase[%0d]: got %0d want %0d", b, log_phase[b],
                             exp_ph[b]);
      end
    end
    checks++;
    if (out_max_s[2] !== 4'd4 || out_idx_s[2] !== 4'd5 || out_bin_s[2] !== 3'd2) begin
      failures++; $display("FAIL wrap_out: got %0d/%0d/%0d want 4/5/2", out_max_s[2],
                           out_idx_s[2], out_bin_s[2]);
    end
    release_result(2);
  endtask

  task automatic test_ignored_inputs();
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    checks++;
    if (bin_start_s[1] !== 1'b1 || busy_s[1] !== 1'b1) begin
      failures++; $display("FAIL ign_config: got bs%b b%b want bs1 b1", bin_start_s[1],
                           busy_s[1]);
    end
    // Result offered during CONFIG must not be taken.
    valid_s[1] = 1'b1; in_max_s[1] = 4'd15; in_idx_s[1] = 4'd15;
    tick();
    valid_s[1] = 1'b0;
    checks++;
    if (tready_s[1] !== 1'b1) begin failures++; $display("FAIL ign_wait_ready: got 0 want 1"); end
    // Start during WAIT must not restart the bin.
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    checks++;
    if (bin_start_s[1] !== 1'b0 || tready_s[1] !== 1'b1) begin
      failures++; $display("FAIL ign_start: got bs%b r%b want bs0 r1", bin_start_s[1],
                           tready_s[1]);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (tready_s[1] !== 1'b1 || busy_s[1] !== 1'b1) begin
      failures++; $display("FAIL ign_no_timeout: got r%b b%b want r1 b1", tready_s[1],
                           busy_s[1]);
    end
    fd_max[0] = 1; fd_max[1] = 2; fd_max[2] = 3; fd_max[3] = 2;
    fd_idx[0] = 8; fd_idx[1] = 9; fd_idx[2] = 10; fd_idx[3] = 11;
    feed(1, 4, 1'b0);
    checks++;
    if (log_timeout !== 1'b0 || log_hs != 4 || log_nbs != 3) begin
      failures++; $display("FAIL ign_counts: got hs%0d nbs%0d to%b want hs4 nbs3 to0", log_hs,
                           log_nbs, log_timeout);
    end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (log_phase[b] !== 10'(b + 1)) begin
        failures++; $display("FAIL ign_phase[%0d]: got %0d want %0d", b, log_phase[b], b + 1);
      end
    end
    checks++;
    if (out_max_s[1] !== 4'd3 || out_idx_s[1] !== 4'd10 || out_bin_s[1] !== 3'd2) begin
      failures++; $display("FAIL ign_out: got %0d/%0d/%0d want 3/10/2", out_max_s[1],
                           out_idx_s[1], out_bin_s[1]);
    end
    release_result(1);
  endtask

  task automatic test_reset_midsweep();
    fd_max[0] = 5; fd_max[1] = 6;
    fd_idx[0] = 1; fd_idx[1] = 2;
    feed(1, 2, 1'b1);
    checks++;
    if (log_hs != 2 || tready_s[1] !== 1'b1 || phase_s[1] !== 10'd2) begin
      failures++; $display("FAIL mid_reach_bin2: got hs%0d r%b ph%0d want hs2 r1 ph2", log_hs,
                           tready_s[1], phase_s[1]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_s[1] !== 1'b0 || bin_start_s[1] !== 1'b0 || tready_s[1] !== 1'b0 ||
        tvalid_s[1] !== 1'b0 || phase_s[1] !== 10'd0) begin
      failures++; $display("FAIL mid_reset_ctl: got b%b bs%b r%b v%b ph%0d want 0 0 0 0 0",
                           busy_s[1], bin_start_s[1], tready_s[1], tvalid_s[1], phase_s[1]);
    end
    checks++;
    if (out_max_s[1] !== 4'd0 || out_idx_s[1] !== 4'd0 || out_bin_s[1] !== 3'd0) begin
      failures++; $display("FAIL mid_reset_out: got %0d/%0d/%0d want 0/0/0", out_max_s[1],
                           out_idx_s[1], out_bin_s[1]);
    end
    fd_max[0] = 4; fd_max[1] = 4; fd_max[2] = 1; fd_max[3] = 4;
    fd_idx[0] = 7; fd_idx[1] = 3; fd_idx[2] = 2; fd_idx[3] = 1;
    feed(1, 4, 1'b1);
    checks++;
    if (log_timeout !== 1'b0 || log_nbs != 4 || log_cycles != 13) begin
      failures++; $display("FAIL mid_rerun: got nbs%0d cyc%0d to%b want nbs4 cyc13 to0",
                           log_nbs, log_cycles, log_timeout);
    end
    checks++;
    if (log_phase[0] !== 10'd0 || log_phase[3] !== 10'd3) begin
      failures++; $display("FAIL mid_rerun_phase: got %0d..%0d want 0..3", log_phase[0],
                           log_phase[3]);
    end
    checks++;
    if (out_max_s[1] !== 4'd4 || out_idx_s[1] !== 4'd7 || out_bin_s[1] !== 3'd0) begin
      failures++; $display("FAIL mid_rerun_out: got %0d/%0d/%0d want 4/7/0", out_max_s[1],
                           out_idx_s[1], out_bin_s[1]);
    end
    release_result(1);
  endtask

  task automatic test_back_to_back();
    fd_max[0] = 4; fd_idx[0] = 1;
    feed(0, 1, 1'b1);
    checks++;
    if (out_max_s[0] !== 4'd4 || out_idx_s[0] !== 4'd1) begin
      failures++; $display("FAIL b2b_first: got %0d/%0d want 4/1", out_max_s[0], out_idx_s[0]);
    end
    release_result(0);
    checks++;
    if (busy_s[0] !== 1'b0 || tvalid_s[0] !== 1'b0) begin
      failures++; $display("FAIL b2b_idle: got b%b v%b want b0 v0", busy_s[0], tvalid_s[0]);
    end
    // Start in the very first idle cycle; bin 0 loads even though smaller.
    fd_max[0] = 2; fd_idx[0] = 8;
    feed(0, 1, 1'b1);
    checks++;
    if (log_timeout !== 1'b0 || log_nbs != 1 || log_cycles != 4) begin
      failures++; $display("FAIL b2b_restart: got nbs%0d cyc%0d to%b want nbs1 cyc4 to0",
                           log_nbs, log_cycles, log_timeout);
    end
    checks++;
    if (out_max_s[0] !== 4'd2 || out_idx_s[0] !== 4'd8 || out_bin_s[0] !== 3'd0) begin
      failures++; $display("FAIL b2b_second: got %0d/%0d/%0d want 2/8/0", out_max_s[0],
                           out_idx_s[0], out_bin_s[0]);
    end
    release_result(0);
  endtask

  initial begin
    test_reset();
    test_single_bin();
    test_four_bins();
    test_done_hold();
    test_phase_wrap();
    test_ignored_inputs();
    test_reset_midsweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
